// File: rtl/can_pkg.sv
// Shared types and default widths for the CAN bit timing logic.
package can_pkg;

    localparam int unsigned BRP_W_DEF   = 6;
    localparam int unsigned TSEG1_W_DEF = 4;
    localparam int unsigned TSEG2_W_DEF = 3;
    localparam int unsigned SJW_W_DEF   = 2;
    localparam int unsigned POS_W_DEF   = 6;

    typedef enum logic [1:0] {
        SEG_SYNC  = 2'd0,
        SEG_TSEG1 = 2'd1,
        SEG_TSEG2 = 2'd2
    } seg_e;

endpackage

// File: rtl/can_bit_timing_if.sv
// Configuration, bus sample and timing outputs of the CAN bit timing generator.
interface can_bit_timing_if #(
    parameter int unsigned BRP_W   = can_pkg::BRP_W_DEF,
    parameter int unsigned TSEG1_W = can_pkg::TSEG1_W_DEF,
    parameter int unsigned TSEG2_W = can_pkg::TSEG2_W_DEF,
    parameter int unsigned SJW_W   = can_pkg::SJW_W_DEF,
    parameter int unsigned POS_W   = can_pkg::POS_W_DEF
);

    logic               enable;
    logic [BRP_W-1:0]   brp;
    logic [TSEG1_W-1:0] tseg1;
    logic [TSEG2_W-1:0] tseg2;
    logic [SJW_W-1:0]   sjw;
    logic               rx;
    logic               hard_sync_en;
    logic               resync_en;

    logic               tq_tick;
    logic               bit_tick;
    logic               sample_point;
    logic               sync_seg;
    logic               tseg1_active;
    logic               tseg2_active;
    logic [POS_W-1:0]   tq_position;
    logic               sampled_bit;

    modport master (
        output enable, brp, tseg1, tseg2, sjw, rx, hard_sync_en, resync_en,
        input  tq_tick, bit_tick, sample_point, sync_seg, tseg1_active, tseg2_active,
        input  tq_position, sampled_bit
    );

    modport slave (
        input  enable, brp, tseg1, tseg2, sjw, rx, hard_sync_en, resync_en,
        output tq_tick, bit_tick, sample_point, sync_seg, tseg1_active, tseg2_active,
        output tq_position, sampled_bit
    );

endinterface

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: counts 0..brp while enabled and flags the terminal count.
module can_tq_prescaler #(
    parameter int unsigned BRP_W = can_pkg::BRP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [BRP_W-1:0] brp_i,
    output logic             tq_end_o
);

    logic [BRP_W-1:0] pre_q, pre_d;

    always_comb begin
        pre_d    = '0;
        tq_end_o = 1'b0;
        if (enable_i) begin
            tq_end_o = (pre_q == brp_i);
            pre_d    = tq_end_o ? '0 : pre_q + BRP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit timing generator: SYNC/TSEG1/TSEG2 sequencing with hard sync and
// SJW-bounded resynchronisation; every output is driven straight from a flop.
module can_bit_timing
    import can_pkg::*;
#(
    parameter int unsigned BRP_W   = BRP_W_DEF,
    parameter int unsigned TSEG1_W = TSEG1_W_DEF,
    parameter int unsigned TSEG2_W = TSEG2_W_DEF,
    parameter int unsigned SJW_W   = SJW_W_DEF,
    parameter int unsigned POS_W   = POS_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    can_bit_timing_if.slave bus
);

    localparam logic [POS_W-1:0] PosOne = POS_W'(1);
    localparam logic [POS_W-1:0] PosTwo = POS_W'(2);

    seg_e             state_q, state_d;
    logic [POS_W-1:0] cnt_q, cnt_d, ext_q, ext_d, shr_q, shr_d, pos_q, pos_d;
    logic             done_q, done_d, rx_prev_q, rx_prev_d, sampled_q, sampled_d;
    logic             tq_tick_q, tq_tick_d, bit_tick_q, bit_tick_d, sp_q, sp_d;
    logic             sync_q, tseg1_q, tseg2_q;

    logic             tq_end;
    logic [POS_W-1:0] tseg1_len, tseg2_len, sjw_raw, sjw_len;
    logic [POS_W-1:0] ext_n, shr_n, l2_rem;
    logic             edge_det, hard_sync, resync_ok;

    can_tq_prescaler #(
        .BRP_W (BRP_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (bus.enable),
        .brp_i    (bus.brp),
        .tq_end_o (tq_end)
    );

    assign tseg1_len = POS_W'(bus.tseg1) + PosOne;
    assign tseg2_len = POS_W'(bus.tseg2) + PosOne;
    assign sjw_raw   = POS_W'(bus.sjw) + PosOne;
    assign sjw_len   = (sjw_raw < tseg2_len) ? sjw_raw : tseg2_len;

    // Only one correction per bit: resync_done gates both sync kinds until the sample point.
    assign edge_det  = rx_prev_q & ~bus.rx;
    assign hard_sync = bus.hard_sync_en & edge_det & ~done_q;
    assign resync_ok = bus.resync_en & edge_det & ~done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ext_d      = ext_q;
        shr_d      = shr_q;
        pos_d      = pos_q;
        done_d     = done_q;
        rx_prev_d  = rx_prev_q;
        sampled_d  = sampled_q;
        tq_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        sp_d       = 1'b0;
        ext_n      = ext_q;
        shr_n      = shr_q;
        l2_rem     = '0;

        if (!bus.enable) begin
            state_d = SEG_SYNC;
            cnt_d   = '0;
            ext_d   = '0;
            shr_d   = '0;
            done_d  = 1'b0;
            pos_d   = PosOne;
        end else if (tq_end) begin
            tq_tick_d = 1'b1;
            rx_prev_d = bus.rx;
            if (hard_sync) begin
                bit_tick_d = 1'b1;
                state_d    = SEG_TSEG1;
                cnt_d      = '0;
                ext_d      = '0;
                shr_d      = '0;
                done_d     = 1'b1;
            end else begin
                unique case (state_q)
                    SEG_SYNC: begin
                        state_d = SEG_TSEG1;
                        cnt_d   = '0;
                    end
                    SEG_TSEG1: begin
                        if (resync_ok) begin
                            ext_n  = (cnt_q + PosOne < sjw_len) ? cnt_q + PosOne : sjw_len;
                            done_d = 1'b1;
                        end
                        ext_d = ext_n;
                        // End check uses the freshly lengthened segment.
                        if (cnt_q == tseg1_len + ext_n - PosOne) begin
                            state_d   = SEG_TSEG2;
                            cnt_d     = '0;
                            sp_d      = 1'b1;
                            sampled_d = bus.rx;
                            ext_d     = '0;
                            done_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q + PosOne;
                        end
                    end
                    SEG_TSEG2: begin
                        l2_rem = tseg2_len - shr_q - cnt_q - PosOne;
                        if (resync_ok && (l2_rem <= sjw_len)) begin
                            // Edge close enough to the bit end: it becomes the new sync edge.
                            bit_tick_d = 1'b1;
                            state_d    = SEG_TSEG1;
                            cnt_d      = '0;
                            shr_d      = '0;
                            done_d     = 1'b1;
                        end else begin
                            if (resync_ok) begin
                                shr_n  = sjw_len;
                                done_d = 1'b1;
                            end
                            if (cnt_q == tseg2_len - shr_n - PosOne) begin
                                bit_tick_d = 1'b1;
                                state_d    = SEG_SYNC;
                                cnt_d      = '0;
                                shr_d      = '0;
                            end else begin
                                shr_d = shr_n;
                                cnt_d = cnt_q + PosOne;
                            end
                        end
                    end
                    default: state_d = SEG_SYNC;
                endcase
            end

            unique case (state_d)
                SEG_SYNC:  pos_d = PosOne;
                SEG_TSEG1: pos_d = PosTwo + cnt_d;
                default:   pos_d = pos_q + PosOne;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEG_SYNC;
            cnt_q      <= '0;
            ext_q      <= '0;
            shr_q      <= '0;
            pos_q      <= PosOne;
            done_q     <= 1'b0;
            rx_prev_q  <= 1'b1;
            sampled_q  <= 1'b1;
            tq_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            sp_q       <= 1'b0;
            sync_q     <= 1'b1;
            tseg1_q    <= 1'b0;
            tseg2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ext_q      <= ext_d;
            shr_q      <= shr_d;
            pos_q      <= pos_d;
            done_q     <= done_d;
            rx_prev_q  <= rx_prev_d;
            sampled_q  <= sampled_d;
            tq_tick_q  <= tq_tick_d;
            bit_tick_q <= bit_tick_d;
            sp_q       <= sp_d;
            sync_q     <= (state_d == SEG_SYNC);
            tseg1_q    <= (state_d == SEG_TSEG1);
            tseg2_q    <= (state_d == SEG_TSEG2);
        end
    end

    assign bus.tq_tick      = tq_tick_q;
    assign bus.bit_tick     = bit_tick_q;
    assign bus.sample_point = sp_q;
    assign bus.sync_seg     = sync_q;
    assign bus.tseg1_active = tseg1_q;
    assign bus.tseg2_active = tseg2_q;
    assign bus.tq_position  = pos_q;
    assign bus.sampled_bit  = sampled_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed timing scenarios plus randomized traffic, all
// compared cycle by cycle against a position-based model of the bit.
module tb_can_bit_timing;
    import can_pkg::*;

    localparam int unsigned BRP_W   = BRP_W_DEF;
    localparam int unsigned TSEG1_W = TSEG1_W_DEF;
    localparam int unsigned TSEG2_W = TSEG2_W_DEF;
    localparam int unsigned SJW_W   = SJW_W_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    can_bit_timing_if bus ();
    can_bit_timing dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: the bit is a row of TQs numbered from 1; m_l1/m_l2 are the current
    // TSEG1/TSEG2 lengths for this bit, the segment follows from the position.
    int m_div, m_pos, m_l1, m_l2;
    bit m_done, m_prev, m_sampled, e_tick, e_bit, e_sp;
    int prev_obs_pos, sp_prev_pos, bit_pos, max_pos, tq_count;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int seg_of(input int pos);
        if (pos == 1) return 0;
        if (pos <= m_l1 + 1) return 1;
        return 2;
    endfunction

    task automatic new_bit(input int pos);
        m_pos = pos;
        m_l1  = int'(bus.tseg1) + 1;
        m_l2  = int'(bus.tseg2) + 1;
    endtask

    task automatic model_reset();
        m_div = 0; m_done = 1'b0; m_prev = 1'b1; m_sampled = 1'b1;
        e_tick = 1'b0; e_bit = 1'b0; e_sp = 1'b0;
        new_bit(1);
    endtask

    task automatic model_step();
        int  base2, sj, idx, r;
        bit  bnd, edge_seen;
        e_tick = 1'b0; e_bit = 1'b0; e_sp = 1'b0;
        if (!rst_n) begin model_reset(); return; end
        base2 = int'(bus.tseg2) + 1;
        sj    = (int'(bus.sjw) + 1 < base2) ? int'(bus.sjw) + 1 : base2;
        if (!bus.enable) begin
            m_div = 0; m_done = 1'b0; new_bit(1);
            return;
        end
        bnd   = (m_div == int'(bus.brp));
        m_div = bnd ? 0 : m_div + 1;
        if (!bnd) return;
        e_tick    = 1'b1;
        edge_seen = m_prev && !bus.rx;
        m_prev    = bus.rx;
        if (bus.hard_sync_en && edge_seen && !m_done) begin
            e_bit = 1'b1; m_done = 1'b1; new_bit(2);
            return;
        end
        case (seg_of(m_pos))
            0: m_pos = 2;
            1: begin
                idx = m_pos - 2;
                if (bus.resync_en && edge_seen && !m_done) begin
                    m_l1   = int'(bus.tseg1) + 1 + ((idx + 1 < sj) ? idx + 1 : sj);
                    m_done = 1'b1;
                end
                if (m_pos == m_l1 + 1) begin
                    e_sp = 1'b1; m_sampled = bus.rx; m_done = 1'b0;
                end
                m_pos++;
            end
            default: begin
                idx = m_pos - m_l1 - 2;
                if (bus.resync_en && edge_seen && !m_done) begin
                    r      = m_l2 - idx - 1;
                    m_done = 1'b1;
                    if (r <= sj) begin
                        e_bit = 1'b1; new_bit(2);
                        return;
                    end
                    m_l2 = base2 - sj;
                end
                if (m_pos == m_l1 + 1 + m_l2) begin
                    e_bit = 1'b1; new_bit(1);
                end else begin
                    m_pos++;
                end
            end
        endcase
    endtask

    task automatic compare();
        int s;
        s = seg_of(m_pos);
        check_eq("outs", int'({bus.tq_tick, bus.bit_tick, bus.sample_point, bus.sync_seg,
                               bus.tseg1_active, bus.tseg2_active, bus.sampled_bit}),
                 int'({e_tick, e_bit, e_sp, s == 0, s == 1, s == 2, m_sampled}));
        check_eq("tq_position", int'(bus.tq_position), m_pos);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (bus.sample_point) sp_prev_pos = prev_obs_pos;
        prev_obs_pos = int'(bus.tq_position);
    endtask

    task automatic configure(input int brp, input int t1, input int t2, input int sj,
                             input bit hse, input bit rse);
        bus.enable = 1'b0;
        step();
        bus.brp          = BRP_W'(brp);
        bus.tseg1        = TSEG1_W'(t1);
        bus.tseg2        = TSEG2_W'(t2);
        bus.sjw          = SJW_W'(sj);
        bus.hard_sync_en = hse;
        bus.resync_en    = rse;
        bus.rx           = 1'b1;
        step();
        bus.enable = 1'b1;
    endtask

    task automatic sync_bit();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            step();
            seen = bus.bit_tick;
        end
        check_eq("sync_bit_seen", seen, 1);
    endtask

    // Runs one bit from a bit_tick to the next, dropping/raising rx at the start of
    // the given TQ positions (0 disables).
    task automatic measure_bit(input int fall_pos, input int rise_pos, output int clocks);
        bit seen;
        seen = 1'b0; clocks = 0; sp_prev_pos = 0; bit_pos = 0; max_pos = 0; tq_count = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            step();
            clocks++;
            if (bus.tq_tick) tq_count++;
            if (int'(bus.tq_position) > max_pos) max_pos = int'(bus.tq_position);
            if (bus.bit_tick) begin
                seen    = 1'b1;
                bit_pos = int'(bus.tq_position);
            end else if (e_tick && m_pos == fall_pos) begin
                bus.rx = 1'b0;
            end else if (e_tick && m_pos == rise_pos) begin
                bus.rx = 1'b1;
            end
        end
        check_eq("bit_end_seen", seen, 1);
    endtask

    initial begin
        int clocks;
        bit found;
        bus.enable = 1'b0; bus.brp = BRP_W'(3); bus.tseg1 = TSEG1_W'(4);
        bus.tseg2 = TSEG2_W'(1); bus.sjw = '0; bus.rx = 1'b1;
        bus.hard_sync_en = 1'b0; bus.resync_en = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        compare();
        step(); step();
        rst_n = 1'b1;
        step();

        // Nominal bit: 4-clock TQ, 8-TQ bit, sample after position 6.
        configure(3, 4, 1, 0, 1'b0, 1'b1);
        sync_bit();
        measure_bit(0, 0, clocks);
        check_eq("nom_bit_clocks", clocks, 32);
        check_eq("nom_tq_per_bit", tq_count, 8);
        check_eq("nom_sp_pos", sp_prev_pos, 6);
        check_eq("nom_max_pos", max_pos, 8);
        check_eq("nom_next_pos", bit_pos, 1);

        // Edge in TSEG1 at cnt=2 lengthens TSEG1 by 2.
        configure(3, 4, 1, 1, 1'b0, 1'b1);
        sync_bit();
        measure_bit(4, 6, clocks);
        check_eq("ext_bit_clocks", clocks, 40);
        check_eq("ext_sp_pos", sp_prev_pos, 8);

        // Edge late in TSEG2 ends the bit at once and skips SYNC.
        configure(3, 4, 3, 1, 1'b0, 1'b1);
        sync_bit();
        measure_bit(9, 0, clocks);
        check_eq("shr_bit_clocks", clocks, 36);
        check_eq("shr_next_pos", bit_pos, 2);
        measure_bit(0, 0, clocks);
        check_eq("shr_after_clocks", clocks, 36);

        // Hard sync at position 7, then a second edge in the same bit is ignored.
        configure(3, 4, 1, 0, 1'b1, 1'b0);
        sync_bit();
        measure_bit(7, 0, clocks);
        check_eq("hard_bit_clocks", clocks, 28);
        check_eq("hard_next_pos", bit_pos, 2);
        measure_bit(4, 3, clocks);
        check_eq("hard_second_clocks", clocks, 28);
        check_eq("hard_second_next_pos", bit_pos, 1);

        // Asynchronous reset in TSEG2, then first TQ after brp+1 clocks.
        configure(3, 4, 1, 0, 1'b0, 1'b1);
        sync_bit();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (m_pos == 7);
        end
        check_eq("reach_tseg2", found, 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        check_eq("rst_pos", int'(bus.tq_position), 1);
        step(); step();
        rst_n = 1'b1;
        found = 1'b0;
        clocks = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            clocks++;
            found = bus.tq_tick;
        end
        check_eq("first_tq_clocks", clocks, 4);

        // Randomized configurations and bus traffic.
        for (int c = 0; c < 12; c++) begin
            configure($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            for (int k = 0; k < 400; k++) begin
                step();
                if ($urandom_range(0, 7) == 0) bus.rx = ~bus.rx;
                bus.enable = ($urandom_range(0, 99) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
